// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// The datapath width is fixed by the CLA_16bit adder it drives.
package mult_pkg;

    localparam int MULT_WIDTH = 16;
    localparam int MULT_ITER  = 16;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : mult_pkg

// File: rtl/CLA_16bit.sv
// 16-bit two-level carry-lookahead adder.
// Four 4-bit lookahead groups are combined by a second lookahead level.
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [15:0] p_s;
    logic [15:0] g_s;
    logic [15:0] carry_s;
    logic [3:0]  grp_p_s;
    logic [3:0]  grp_g_s;
    logic [4:0]  grp_c_s;

    // Carries into each bit of a 4-bit group, fully expanded from the group carry-in.
    function automatic logic [3:0] grp_carry(input logic [3:0] p, input logic [3:0] g, input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic grp_prop(input logic [3:0] p);
        return &p;
    endfunction

    // Bit-level propagate/generate, group terms, second-level lookahead and sum.
    always_comb begin
        p_s = a ^ b;
        g_s = a & b;
        for (int k = 0; k < 4; k++) begin
            grp_p_s[k] = grp_prop(p_s[k*4 +: 4]);
            grp_g_s[k] = grp_gen(p_s[k*4 +: 4], g_s[k*4 +: 4]);
        end
        grp_c_s[0] = c_in;
        grp_c_s[1] = grp_g_s[0] | (grp_p_s[0] & c_in);
        grp_c_s[2] = grp_g_s[1] | (grp_p_s[1] & grp_g_s[0]) | (grp_p_s[1] & grp_p_s[0] & c_in);
        grp_c_s[3] = grp_g_s[2] | (grp_p_s[2] & grp_g_s[1]) | (grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
                   | (grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & c_in);
        grp_c_s[4] = grp_g_s[3] | (grp_p_s[3] & grp_g_s[2]) | (grp_p_s[3] & grp_p_s[2] & grp_g_s[1])
                   | (grp_p_s[3] & grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
                   | (grp_p_s[3] & grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & c_in);
        for (int k = 0; k < 4; k++) begin
            carry_s[k*4 +: 4] = grp_carry(p_s[k*4 +: 4], g_s[k*4 +: 4], grp_c_s[k]);
        end
        sum   = p_s ^ carry_s;
        c_out = grp_c_s[4];
    end

endmodule : CLA_16bit

// File: rtl/seq_mult_16bit.sv
// Iterative unsigned 16x16->32 shift-add multiplier with valid/ready handshakes.
// One CLA_16bit addition per cycle; the carry-out is shifted into the accumulator MSB.
module seq_mult_16bit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int ITER  = MULT_ITER
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    state_e               state_r, state_nx_s;
    logic [WIDTH-1:0]     mcand_r, mcand_nx_s;
    logic [WIDTH-1:0]     acc_hi_r, acc_hi_nx_s;
    logic [WIDTH-1:0]     q_r, q_nx_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
    logic [2*WIDTH-1:0]   product_r, product_nx_s;
    logic                 in_ready_r, busy_r, out_valid_r;

    logic [WIDTH-1:0]     add_b_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 c_out_s;

    // Partial-product addend: multiplicand when the current multiplier bit is set.
    always_comb begin
        if (q_r[0]) begin
            add_b_s = mcand_r;
        end else begin
            add_b_s = {WIDTH{1'b0}};
        end
    end

    CLA_16bit u_cla (
        .a     (acc_hi_r),
        .b     (add_b_s),
        .c_in  (1'b0),
        .sum   (sum_s),
        .c_out (c_out_s)
    );

    // Next-state, datapath update and product capture.
    always_comb begin
        state_nx_s   = state_r;
        mcand_nx_s   = mcand_r;
        acc_hi_nx_s  = acc_hi_r;
        q_nx_s       = q_r;
        cnt_nx_s     = cnt_r;
        product_nx_s = product_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    mcand_nx_s  = op_a;
                    q_nx_s      = op_b;
                    acc_hi_nx_s = {WIDTH{1'b0}};
                    cnt_nx_s    = {CNT_W{1'b0}};
                    state_nx_s  = BUSY;
                end else begin
                    state_nx_s  = IDLE;
                end
            end
            BUSY: begin
                // {c_out, sum, q} shifted right by one, dropping the LSB.
                acc_hi_nx_s = {c_out_s, sum_s[WIDTH-1:1]};
                q_nx_s      = {sum_s[0], q_r[WIDTH-1:1]};
                cnt_nx_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(ITER - 1)) begin
                    state_nx_s   = DONE;
                    product_nx_s = {c_out_s, sum_s, q_r[WIDTH-1:1]};
                end else begin
                    state_nx_s   = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mcand_r     <= {WIDTH{1'b0}};
            acc_hi_r    <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            product_r   <= {(2*WIDTH){1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            mcand_r     <= mcand_nx_s;
            acc_hi_r    <= acc_hi_nx_s;
            q_r         <= q_nx_s;
            cnt_r       <= cnt_nx_s;
            product_r   <= product_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            busy_r      <= (state_nx_s == BUSY);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign product   = product_r;

endmodule : seq_mult_16bit

// File: tb/tb_seq_mult_16bit.sv
// Randomized self-checking bench for seq_mult_16bit against a plain a*b reference model.
module tb_seq_mult_16bit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks;
    int errors;
    int cyc;
    int last_accept;

    seq_mult_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter for latency and spacing checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete multiply: accept, iterate, backpressure, handoff.
    task automatic do_mult(input logic [15:0] a, input logic [15:0] b, input int hold, input bit check_gap);
        logic [31:0] exp;
        int n;
        exp = 32'(a) * 32'(b);
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check_val("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        tick();
        if (check_gap) check_val("accept_gap_ge18", 32'((cyc - last_accept) >= 18), 32'd1);
        last_accept = cyc;
        in_valid = 1'b0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        check_val("busy_after_accept", {30'd0, busy, in_ready}, 32'd2);
        n = 0;
        do begin
            in_valid  = 1'($urandom_range(0, 1));
            op_a      = 16'($urandom);
            op_b      = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end while (!out_valid && n < 40);
        out_ready = 1'b0;
        check_val("latency", 32'(n), 32'd16);
        check_val("product", product, exp);
        check_val("done_flags", {29'd0, out_valid, busy, in_ready}, 32'd4);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a     = 16'($urandom);
            tick();
            check_val("hold_product", product, exp);
            check_val("hold_flags", {29'd0, out_valid, busy, in_ready}, 32'd4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("handoff_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
        check_val("product_kept", product, exp);
    endtask

    initial begin
        int ov_seen;
        checks = 0;
        errors = 0;
        cyc = 0;
        last_accept = -100;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = 16'd0;
        op_b = 16'd0;
        repeat (3) tick();
        check_val("rst_outputs", {product[30:0], out_valid}, 32'd0);
        check_val("rst_flags", {30'd0, busy, in_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
        check_val("post_rst_product", product, 32'd0);

        do_mult(16'd3, 16'd5, 0, 1'b0);
        do_mult(16'hFFFF, 16'hFFFF, 5, 1'b0);
        do_mult(16'h8000, 16'h0002, 0, 1'b0);
        do_mult(16'h0000, 16'h1234, 1, 1'b0);
        do_mult(16'hABCD, 16'h0001, 0, 1'b0);
        check_val("identity_const", product, 32'h0000ABCD);

        // Asynchronous reset mid-cycle while a product is being offered.
        in_valid = 1'b1;
        op_a = 16'h0101;
        op_b = 16'h0202;
        tick();
        in_valid = 1'b0;
        repeat (16) tick();
        check_val("pre_async_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_clear", {product[29:0], out_valid, busy}, 32'd0);
        check_val("async_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Abort partway through an iteration run.
        in_valid = 1'b1;
        op_a = 16'h1234;
        op_b = 16'h5678;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check_val("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_busy_cleared", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        check_val("abort_no_output", 32'(ov_seen), 32'd0);

        do_mult(16'h1234, 16'h5678, 0, 1'b0);
        check_val("b2b_first_const", product, 32'h06260060);
        do_mult(16'h00FF, 16'h0100, 0, 1'b1);
        check_val("b2b_second_const", product, 32'h0000FF00);

        for (int t = 0; t < 20; t++) begin
            do_mult(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_mult_16bit
